ps2_direction_decoder: RTL

Turns the byte stream from the PS/2 receiver into lightbike steering commands for one player. Tracks E0 (extended) and F0 (break) prefixes, keeps the held state of the four direction keys for the selected keyset, and emits a one-cycle `dir_valid` pulse with the new heading on each accepted key press. Sits between the PS/2 receiver and the player movement logic, one instance per player.

---
 rtl/lb_keys_pkg.sv | 61 ++++++
 rtl/keyset_code_match.sv | 82 ++++++++
 rtl/ps2_direction_decoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lb_keys_pkg.sv
// lb_keys_pkg
// Shared constants for the lightbike keyboard steering path: PS/2 prefix
// bytes, the per-keyset scan codes, the heading encoding and the prefix FSM
// state encoding. Imported by keyset_code_match and ps2_direction_decoder.
// No ports (package).
package lb_keys_pkg;

    // PS/2 prefix bytes
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    // Heading encoding; also the bit index into the held-key vector
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // Keyset 1
    localparam logic [7:0] K1_LEFT  = 8'h1C;
    localparam logic [7:0] K1_RIGHT = 8'h23;
    localparam logic [7:0] K1_UP    = 8'h1D;
    localparam logic [7:0] K1_DOWN  = 8'h1B;

    // Keyset 2
    localparam logic [7:0] K2_LEFT  = 8'h2B;
    localparam logic [7:0] K2_RIGHT = 8'h33;
    localparam logic [7:0] K2_UP    = 8'h2C;
    localparam logic [7:0] K2_DOWN  = 8'h34;

    // Keyset 3
    localparam logic [7:0] K3_LEFT  = 8'h3B;
    localparam logic [7:0] K3_RIGHT = 8'h4B;
    localparam logic [7:0] K3_UP    = 8'h43;
    localparam logic [7:0] K3_DOWN  = 8'h42;

    // Keyset 4, plain keypad codes
    localparam logic [7:0] K4_LEFT  = 8'h6B;
    localparam logic [7:0] K4_RIGHT = 8'h74;
    localparam logic [7:0] K4_UP    = 8'h75;
    localparam logic [7:0] K4_DOWN  = 8'h73;

    // Keyset 4, E0-prefixed arrow-cluster codes (only down differs)
    localparam logic [7:0] K4X_LEFT  = 8'h6B;
    localparam logic [7:0] K4X_RIGHT = 8'h74;
    localparam logic [7:0] K4X_UP    = 8'h75;
    localparam logic [7:0] K4X_DOWN  = 8'h72;

    // Prefix tracking states
    typedef enum logic [1:0] {
        PFX_IDLE    = 2'd0,
        PFX_EXT     = 2'd1,
        PFX_BRK     = 2'd2,
        PFX_EXT_BRK = 2'd3
    } prefix_state_t;

    // up<->down and left<->right differ only in the upper encoding bit
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/keyset_code_match.sv
// keyset_code_match
// Combinational lookup of one scan code against the selected keyset.
// Ports:
//   keyset [KEYSET_W]  binding selector 1..4 (0 and 5..7 behave as 1)
//   code   [8]         scan code byte (prefixes already stripped)
//   ext    [1]         byte was preceded by E0
//   hit    [1]         code is a direction key of this keyset
//   dir    [2]         matched heading (0 up, 1 right, 2 down, 3 left)
module keyset_code_match
    import lb_keys_pkg::*;
#(
    parameter int KEYSET_W = 3
) (
    input  logic [KEYSET_W-1:0] keyset,
    input  logic [7:0]          code,
    input  logic                ext,
    output logic                hit,
    output logic [1:0]          dir
);

    logic [31:0] keyset_wide;

    assign keyset_wide = 32'(keyset);

    // Only keyset 4 has an extended (E0) binding; every other keyset
    // rejects extended bytes outright.
    always_comb begin
        hit = 1'b0;
        dir = DIR_UP;
        if (ext) begin
            if (keyset_wide == 32'd4) begin
                case (code)
                    K4X_LEFT:  begin hit = 1'b1; dir = DIR_LEFT;  end
                    K4X_RIGHT: begin hit = 1'b1; dir = DIR_RIGHT; end
                    K4X_UP:    begin hit = 1'b1; dir = DIR_UP;    end
                    K4X_DOWN:  begin hit = 1'b1; dir = DIR_DOWN;  end
                    default:   ;
                endcase
            end
        end else begin
            case (keyset_wide)
                32'd2: begin
                    case (code)
                        K2_LEFT:  begin hit = 1'b1; dir = DIR_LEFT;  end
                        K2_RIGHT: begin hit = 1'b1; dir = DIR_RIGHT; end
                        K2_UP:    begin hit = 1'b1; dir = DIR_UP;    end
                        K2_DOWN:  begin hit = 1'b1; dir = DIR_DOWN;  end
                        default:  ;
                    endcase
                end
                32'd3: begin
                    case (code)
                        K3_LEFT:  begin hit = 1'b1; dir = DIR_LEFT;  end
                        K3_RIGHT: begin hit = 1'b1; dir = DIR_RIGHT; end
                        K3_UP:    begin hit = 1'b1; dir = DIR_UP;    end
                        K3_DOWN:  begin hit = 1'b1; dir = DIR_DOWN;  end
                        default:  ;
                    endcase
                end
                32'd4: begin
                    case (code)
                        K4_LEFT:  begin hit = 1'b1; dir = DIR_LEFT;  end
                        K4_RIGHT: begin hit = 1'b1; dir = DIR_RIGHT; end
                        K4_UP:    begin hit = 1'b1; dir = DIR_UP;    end
                        K4_DOWN:  begin hit = 1'b1; dir = DIR_DOWN;  end
                        default:  ;
                    endcase
                end
                default: begin
                    case (code)
                        K1_LEFT:  begin hit = 1'b1; dir = DIR_LEFT;  end
                        K1_RIGHT: begin hit = 1'b1; dir = DIR_RIGHT; end
                        K1_UP:    begin hit = 1'b1; dir = DIR_UP;    end
                        K1_DOWN:  begin hit = 1'b1; dir = DIR_DOWN;  end
                        default:  ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder
// Converts the PS/2 byte stream into steering commands for one player.
// Tracks E0/F0 prefixes, keeps the held state of the four direction keys
// and pulses dir_valid with the new heading on each accepted press.
// Optional feature: define LB_REVERSE_BLOCK_EN to ignore 180-degree
// reversals (held is still updated, dir and dir_valid are not).
// Ports:
//   clock               system clock, rising edge
//   reset_n             asynchronous active-low reset
//   clear               synchronous restart clear, highest priority
//   scan_code [8]       byte from the PS/2 receiver
//   scan_valid          one-cycle strobe for scan_code
//   keyset [KEYSET_W]   key-binding selector 1..4
//   dir [2]             current heading (0 up, 1 right, 2 down, 3 left)
//   dir_valid           one-cycle pulse when dir is written by a press
//   held [4]            held keys {left, down, right, up}
module ps2_direction_decoder
    import lb_keys_pkg::*;
#(
    parameter int KEYSET_W = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear,
    input  logic [7:0]          scan_code,
    input  logic                scan_valid,
    input  logic [KEYSET_W-1:0] keyset,
    output logic [1:0]          dir,
    output logic                dir_valid,
    output logic [3:0]          held
);

    prefix_state_t       state;
    prefix_state_t       state_next;
    logic [KEYSET_W-1:0] keyset_q;
    logic                keyset_q_valid;
    logic                keyset_change;

    logic                is_ext;
    logic                is_brk;
    logic                byte_take;
    logic                match_hit;
    logic [1:0]          match_dir;
    logic                make_hit;
    logic                break_hit;
    logic                reverse_blocked;
    logic                accept;
    logic [3:0]          held_next;
    logic [1:0]          dir_next;

    // keyset_q_valid stays low for the first cycle after reset so the
    // register effectively starts equal to the live input without needing
    // an asynchronous load of a non-constant value.
    assign keyset_change = keyset_q_valid && (keyset_q != keyset);

    // State register: prefix FSM plus the registered keyset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= PFX_IDLE;
            keyset_q       <= '0;
            keyset_q_valid <= 1'b0;
        end else begin
            state          <= state_next;
            keyset_q       <= keyset;
            keyset_q_valid <= 1'b1;
        end
    end

    // Next-state logic: clear and keyset change abort any pending prefix
    always_comb begin
        state_next = state;
        if (clear || keyset_change) begin
            state_next = PFX_IDLE;
        end else if (scan_valid) begin
            if (scan_code == CODE_EXT) begin
                state_next = PFX_EXT;
            end else if (scan_code == CODE_BRK) begin
                if (state == PFX_EXT || state == PFX_EXT_BRK) begin
                    state_next = PFX_EXT_BRK;
                end else begin
                    state_next = PFX_BRK;
                end
            end else begin
                state_next = PFX_IDLE;
            end
        end
    end

    assign is_ext = (state == PFX_EXT) || (state == PFX_EXT_BRK);
    assign is_brk = (state == PFX_BRK) || (state == PFX_EXT_BRK);

    keyset_code_match #(
        .KEYSET_W (KEYSET_W)
    ) u_match (
        .keyset (keyset),
        .code   (scan_code),
        .ext    (is_ext),
        .hit    (match_hit),
        .dir    (match_dir)
    );

`ifdef LB_REVERSE_BLOCK_EN
    assign reverse_blocked = (match_dir == opposite_dir(dir));
`else
    assign reverse_blocked = 1'b0;
`endif

    // Output logic: a final (non-prefix) byte either presses or releases a
    // key. A press already held is a typematic repeat and changes nothing;
    // a blocked reversal still marks the key as held.
    always_comb begin
        byte_take = scan_valid && !clear && !keyset_change &&
                    (scan_code != CODE_EXT) && (scan_code != CODE_BRK);
        make_hit  = byte_take && match_hit && !is_brk;
        break_hit = byte_take && match_hit && is_brk;
        accept    = make_hit && !held[match_dir] && !reverse_blocked;
        held_next = held;
        dir_next  = dir;
        if (make_hit) begin
            held_next[match_dir] = 1'b1;
        end
        if (break_hit) begin
            held_next[match_dir] = 1'b0;
        end
        if (accept) begin
            dir_next = match_dir;
        end
    end

    // Output registers. A keyset change keeps the heading but forgets keys
    // held under the old bindings.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dir       <= DIR_UP;
            dir_valid <= 1'b0;
            held      <= '0;
        end else if (clear) begin
            dir       <= DIR_UP;
            dir_valid <= 1'b0;
            held      <= '0;
        end else if (keyset_change) begin
            dir_valid <= 1'b0;
            held      <= '0;
        end else begin
            dir       <= dir_next;
            dir_valid <= accept;
            held      <= held_next;
        end
    end

endmodule
